// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
// Holds the datapath widths, ALU op codes, command type codes and the
// sequencer FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int NREG   = 4;
    localparam int REG_AW = $clog2(NREG);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;

    localparam logic CMD_LOAD = 1'b0;
    localparam logic CMD_ALU  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command bus into the ALU sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; the command fields must be stable while
// cmd_valid is high, and cmd_ready may drop without waiting for cmd_valid.
//   master : drives cmd_valid, cmd_type, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm
//   slave  : drives cmd_ready
interface alu_op_sequencer_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_type;
    logic [1:0]        cmd_op;
    logic [REG_AW-1:0] cmd_rd;
    logic [REG_AW-1:0] cmd_rs1;
    logic [REG_AW-1:0] cmd_rs2;
    logic [DATA_W-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_type, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready
    );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DATA_W register file for the ALU sequencer.
// Ports: clk, rst_n (async active-low clear), one synchronous write port
// (we/waddr/wdata) and three combinational read ports (rs1, rs2, dbg).
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = mem[raddr1];
    assign rdata2   = mem[raddr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer placed upstream of a combinational 4-bit ALU.
// Accepts LOAD / ALU commands on the cmd bus, drives registered operands and
// op select to the ALU, and writes the result (or immediate) back into the
// register file.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   cmd              : command bus (slave side)
//   alu_a/b/op_sel   : registered ALU inputs; alu_result: ALU output
//   wb_valid/rd/data : write-back pulse, destination and value
//   z_flag, op_count : last written value was zero; completed command count
//   dbg_addr/data    : combinational register file peek
//   dbg_state        : current FSM state
module alu_op_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave cmd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              z_flag,
    output logic [7:0]        op_count,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic              accept, do_load, do_alu;
    logic              we;
    logic [REG_AW-1:0] waddr, rd_q;
    logic [DATA_W-1:0] wdata, rs1_data, rs2_data;

    // rst_n is folded in so the bus never sees ready during reset.
    assign cmd.cmd_ready = (state_q == ST_IDLE) && rst_n;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign do_load       = accept && (cmd.cmd_type == CMD_LOAD);
    assign do_alu        = accept && (cmd.cmd_type == CMD_ALU);

    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        waddr   = cmd.cmd_rd;
        wdata   = cmd.cmd_imm;
        case (state_q)
            ST_IDLE: begin
                if (do_alu) begin
                    state_d = ST_ISSUE;
                end else if (do_load) begin
                    // LOAD writes on its accept edge, no ISSUE cycle.
                    state_d = ST_WB;
                    we      = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WB;
                we      = 1'b1;
                waddr   = rd_q;
                wdata   = alu_result;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op_sel <= '0;
            rd_q       <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
            z_flag     <= 1'b0;
            op_count   <= '0;
        end else begin
            state_q <= state_d;
            // Operands come from the pre-write register values, so rd may
            // alias rs1/rs2 safely.
            if (do_alu) begin
                alu_a      <= rs1_data;
                alu_b      <= rs2_data;
                alu_op_sel <= cmd.cmd_op;
                rd_q       <= cmd.cmd_rd;
            end
            if (we) begin
                wb_rd    <= waddr;
                wb_data  <= wdata;
                z_flag   <= (wdata == '0);
                op_count <= op_count + 8'd1;
            end
        end
    end

    assign wb_valid  = (state_q == ST_WB);
    assign dbg_state = state_q;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (cmd.cmd_rs1),
        .rdata1   (rs1_data),
        .raddr2   (cmd.cmd_rs2),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer with a behavioural ALU downstream.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    alu_op_sequencer_if cmd_bus ();

    logic [DATA_W-1:0] alu_a, alu_b, alu_result, wb_data, dbg_data;
    logic [1:0]        alu_op_sel, wb_rd, dbg_addr;
    logic              wb_valid, z_flag;
    logic [7:0]        op_count;
    state_t            dbg_state;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op_sel (alu_op_sel),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .z_flag     (z_flag),
        .op_count   (op_count),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .dbg_state  (dbg_state)
    );

    // Downstream ALU: ADD, AND, OR, XOR, modulo 2^DATA_W.
    always_comb begin
        alu_result = '0;
        case (alu_op_sel)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a & alu_b;
            2'b10: alu_result = alu_a | alu_b;
            2'b11: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int wb_pulses = 0;
    logic [5:0] exp_q[$];   // {wb_rd, wb_data}
    int pulse_cyc[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       typ;
        logic [1:0] op, rd, rs1, rs2;
        logic [3:0] imm;
        logic [3:0] exp_wb;
        logic       exp_z;
        logic [7:0] exp_cnt;
        logic [3:0] exp_a, exp_b;
        logic [1:0] exp_op;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic typ, input logic [1:0] op, input logic [1:0] rd,
                                input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm,
                                input logic [3:0] exp_wb, input logic exp_z, input logic [7:0] exp_cnt,
                                input logic [3:0] exp_a, input logic [3:0] exp_b, input logic [1:0] exp_op);
        vec_t v;
        v.typ = typ; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.exp_wb = exp_wb; v.exp_z = exp_z; v.exp_cnt = exp_cnt;
        v.exp_a = exp_a; v.exp_b = exp_b; v.exp_op = exp_op;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic issue(input logic typ, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm);
        int n;
        cmd_bus.cmd_type  = typ;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_rd    = rd;
        cmd_bus.cmd_rs1   = rs1;
        cmd_bus.cmd_rs2   = rs2;
        cmd_bus.cmd_imm   = imm;
        cmd_bus.cmd_valid = 1'b1;
        n = 0;
        while (!cmd_bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready_timeout", int'(cmd_bus.cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_bus.cmd_ready && n < 50);
        check("idle_timeout", int'(cmd_bus.cmd_ready), 1);
    endtask

    task automatic peek(input string name, input logic [1:0] addr, input int exp);
        dbg_addr = addr;
        #1;
        check(name, int'(dbg_data), exp);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst_n = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        repeat (ncyc) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- main ----------------
    initial begin
        int p0;
        int acc [3];
        logic [3:0] imm;

        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_type  = CMD_LOAD;
        cmd_bus.cmd_op    = OP_ADD;
        cmd_bus.cmd_rd    = 2'd0;
        cmd_bus.cmd_rs1   = 2'd0;
        cmd_bus.cmd_rs2   = 2'd0;
        cmd_bus.cmd_imm   = 4'd0;
        dbg_addr = 2'd0;

        // Write-back monitor: every wb_valid cycle must match the next expectation.
        fork
            forever begin
                @(negedge clk);
                if (wb_valid) begin
                    wb_pulses++;
                    pulse_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("wb_unexpected_pulse", 1, 0);
                    end else begin
                        check("wb_rd_data", int'({wb_rd, wb_data}), int'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        vecs[0]  = mk(CMD_LOAD, 2'd0, 2'd0, 2'd0, 2'd0, 4'd12, 4'd12, 1'b0, 8'd1,  4'd0,  4'd0,  2'd0);
        vecs[1]  = mk(CMD_LOAD, 2'd0, 2'd1, 2'd0, 2'd0, 4'd4,  4'd4,  1'b0, 8'd2,  4'd0,  4'd0,  2'd0);
        vecs[2]  = mk(CMD_ALU,  2'd0, 2'd2, 2'd0, 2'd1, 4'd0,  4'd0,  1'b1, 8'd3,  4'd12, 4'd4,  2'd0);
        vecs[3]  = mk(CMD_LOAD, 2'd0, 2'd0, 2'd0, 2'd0, 4'd15, 4'd15, 1'b0, 8'd4,  4'd12, 4'd4,  2'd0);
        vecs[4]  = mk(CMD_LOAD, 2'd0, 2'd1, 2'd0, 2'd0, 4'd10, 4'd10, 1'b0, 8'd5,  4'd12, 4'd4,  2'd0);
        vecs[5]  = mk(CMD_ALU,  2'd1, 2'd3, 2'd0, 2'd1, 4'd0,  4'd10, 1'b0, 8'd6,  4'd15, 4'd10, 2'd1);
        vecs[6]  = mk(CMD_LOAD, 2'd0, 2'd0, 2'd0, 2'd0, 4'd5,  4'd5,  1'b0, 8'd7,  4'd15, 4'd10, 2'd1);
        vecs[7]  = mk(CMD_LOAD, 2'd0, 2'd1, 2'd0, 2'd0, 4'd3,  4'd3,  1'b0, 8'd8,  4'd15, 4'd10, 2'd1);
        vecs[8]  = mk(CMD_ALU,  2'd0, 2'd0, 2'd0, 2'd1, 4'd0,  4'd8,  1'b0, 8'd9,  4'd5,  4'd3,  2'd0);
        vecs[9]  = mk(CMD_ALU,  2'd1, 2'd0, 2'd0, 2'd1, 4'd0,  4'd0,  1'b1, 8'd10, 4'd8,  4'd3,  2'd1);
        vecs[10] = mk(CMD_ALU,  2'd2, 2'd2, 2'd3, 2'd0, 4'd0,  4'd10, 1'b0, 8'd11, 4'd10, 4'd0,  2'd2);
        vecs[11] = mk(CMD_ALU,  2'd3, 2'd3, 2'd3, 2'd1, 4'd0,  4'd9,  1'b0, 8'd12, 4'd10, 4'd3,  2'd3);
        vecs[12] = mk(CMD_LOAD, 2'd0, 2'd1, 2'd0, 2'd0, 4'd0,  4'd0,  1'b1, 8'd13, 4'd10, 4'd3,  2'd3);

        // ---- reset ----
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_bus.cmd_ready), 0);
        check("rst_alu_a", int'(alu_a), 0);
        check("rst_alu_b", int'(alu_b), 0);
        check("rst_alu_op_sel", int'(alu_op_sel), 0);
        check("rst_wb_valid", int'(wb_valid), 0);
        check("rst_wb_data", int'(wb_data), 0);
        check("rst_wb_rd", int'(wb_rd), 0);
        check("rst_z_flag", int'(z_flag), 0);
        check("rst_op_count", int'(op_count), 0);
        peek("rst_dbg_r0", 2'd0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(cmd_bus.cmd_ready), 1);
        check("post_rst_op_count", int'(op_count), 0);
        check("post_rst_state", int'(dbg_state), int'(ST_IDLE));

        // ---- table-driven vectors ----
        for (int i = 0; i < NVEC; i++) begin
            p0 = wb_pulses;
            exp_q.push_back({vecs[i].rd, vecs[i].exp_wb});
            issue(vecs[i].typ, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            wait_idle();
            check($sformatf("v%0d_wb_data", i), int'(wb_data), int'(vecs[i].exp_wb));
            check($sformatf("v%0d_wb_rd", i), int'(wb_rd), int'(vecs[i].rd));
            check($sformatf("v%0d_z_flag", i), int'(z_flag), int'(vecs[i].exp_z));
            check($sformatf("v%0d_op_count", i), int'(op_count), int'(vecs[i].exp_cnt));
            check($sformatf("v%0d_alu_a", i), int'(alu_a), int'(vecs[i].exp_a));
            check($sformatf("v%0d_alu_b", i), int'(alu_b), int'(vecs[i].exp_b));
            check($sformatf("v%0d_alu_op_sel", i), int'(alu_op_sel), int'(vecs[i].exp_op));
            check($sformatf("v%0d_wb_pulses", i), wb_pulses - p0, 1);
            peek($sformatf("v%0d_dbg_rd", i), vecs[i].rd, int'(vecs[i].exp_wb));
        end

        // ---- back-to-back with cmd_valid held high ----
        do_reset(2);
        @(negedge clk);
        p0 = wb_pulses;
        pulse_cyc.delete();
        exp_q.push_back({2'd0, 4'd7});
        exp_q.push_back({2'd1, 4'd14});
        exp_q.push_back({2'd2, 4'd1});
        cmd_bus.cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            cmd_bus.cmd_type = (k == 1) ? CMD_ALU : CMD_LOAD;
            cmd_bus.cmd_op   = OP_ADD;
            cmd_bus.cmd_rd   = 2'(k);
            cmd_bus.cmd_rs1  = 2'd0;
            cmd_bus.cmd_rs2  = 2'd0;
            cmd_bus.cmd_imm  = (k == 0) ? 4'd7 : 4'd1;
            while (!cmd_bus.cmd_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("b2b_ready_timeout", int'(cmd_bus.cmd_ready), 1);
            acc[k] = cyc + 1;
            @(posedge clk);
            @(negedge clk);
        end
        cmd_bus.cmd_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("b2b_accept_gap_alu", acc[1] - acc[0], 2);
        check("b2b_accept_gap_load2", acc[2] - acc[0], 5);
        check("b2b_wb_pulses", wb_pulses - p0, 3);
        check("b2b_pulse_count_q", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            check("b2b_load_wb_cycle", pulse_cyc[0], acc[0]);
            check("b2b_alu_wb_cycle", pulse_cyc[1], acc[1] + 1);
            check("b2b_load2_wb_cycle", pulse_cyc[2], acc[2]);
        end
        check("b2b_op_count", int'(op_count), 3);
        peek("b2b_dbg_r1", 2'd1, 14);

        // ---- 256 LOADs wrap op_count ----
        for (int j = 0; j < 256; j++) begin
            imm = 4'(j + 1);
            exp_q.push_back({2'(j), imm});
            issue(CMD_LOAD, OP_ADD, 2'(j), 2'd0, 2'd0, imm);
        end
        wait_idle();
        check("wrap_op_count", int'(op_count), 3);
        check("wrap_wb_data", int'(wb_data), 0);
        check("wrap_z_flag", int'(z_flag), 1);

        // ---- reset during ISSUE aborts the command ----
        exp_q.push_back({2'd0, 4'd2});
        issue(CMD_LOAD, OP_ADD, 2'd0, 2'd0, 2'd0, 4'd2);
        wait_idle();
        exp_q.push_back({2'd1, 4'd3});
        issue(CMD_LOAD, OP_ADD, 2'd1, 2'd0, 2'd0, 4'd3);
        wait_idle();
        p0 = wb_pulses;
        issue(CMD_ALU, OP_ADD, 2'd2, 2'd0, 2'd1, 4'd0);
        check("abort_in_issue", int'(dbg_state), int'(ST_ISSUE));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_wb_pulse", wb_pulses - p0, 0);
        check("abort_state_idle", int'(dbg_state), int'(ST_IDLE));
        check("abort_ready", int'(cmd_bus.cmd_ready), 1);
        check("abort_op_count", int'(op_count), 0);
        peek("abort_dbg_r2", 2'd2, 0);
        peek("abort_dbg_r1", 2'd1, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required<200000", $time);
        $fatal(1, "timeout");
    end

endmodule
